// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: types and constants shared by the cross_bar slave-side RTL.
// Holds the command encoding, the response FIFO entry and the ack FSM states.
package cross_bar_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMER_W = 4;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [TIMER_W-1:0] timer;
  } resp_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ack_state_e;

  // Saturating one-cycle countdown of a response timer.
  function automatic logic [TIMER_W-1:0] tick(
    input logic [TIMER_W-1:0] t
  );
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/cross_bar_resp_fifo.sv
// cross_bar_resp_fifo: in-order response queue whose entries all count down.
// Ports: clk, rst (async, high), push/din in, pop in, head_data/head_ready/full out.
module cross_bar_resp_fifo
  import cross_bar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  resp_entry_t       din,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_ready,
  output logic              full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t   ent [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

  // A pop frees the slot a simultaneous push needs when full.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data  = ent[rd_ptr].data;
  assign head_ready = !empty && (ent[rd_ptr].timer == '0);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].timer <= tick(ent[i].timer);
      end
      // The acceptance cycle already counts as one elapsed cycle.
      if (push_ok) begin
        ent[wr_ptr].data  <= din.data;
        ent[wr_ptr].timer <= tick(din.timer);
        wr_ptr            <= nxt(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cross_bar_slave_responder.sv
// cross_bar_slave_responder: word-memory slave behind one cross_bar slave port.
// Ports: clk, rst (async, high); req/addr/cmd/wdata in; ack/resp/rdata out.
// Build option CROSS_BAR_SLAVE_RANDOM_STALL_EN adds LFSR-driven ack stalls.
module cross_bar_slave_responder
  import cross_bar_pkg::*;
#(
  parameter int          DEPTH           = 256,
  parameter int          ACK_DELAY       = 1,
  parameter int          RESP_DELAY      = 2,
  parameter int          RESP_FIFO_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(ACK_DELAY + 4) + 1;

  ack_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  load;
  logic [1:0]        extra;
  logic              ack_q;
  logic              ack_c;
  logic              accept;
  logic              space;
  logic              pop;
  logic              full;
  logic              head_ready;
  logic [DATA_W-1:0] head_data;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];
  resp_entry_t       entry;
  logic              unused_addr;

`ifdef CROSS_BAR_SLAVE_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  assign idx         = addr[2 +: IDX_W];
  assign unused_addr = ^{addr[ADDR_W-1:2+IDX_W], addr[1:0]};

  assign pop   = head_ready;
  assign space = !full || pop;
  assign load  = CNT_W'(ACK_DELAY) + CNT_W'(extra);

  // Zero latency: ack straight from IDLE; ACK then serves as a cooldown.
  assign ack_c  = (state == IDLE) && req && space && (load == '0);
  assign ack    = ack_q || ack_c;
  assign accept = req && ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && space) begin
            if (load == '0) begin
              state <= ACK;
            end else if (load == CNT_W'(1)) begin
              ack_q <= 1'b1;
              state <= ACK;
            end else begin
              cnt   <= load;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt > CNT_W'(2)) begin
            cnt <= cnt - 1'b1;
          end else if (space) begin
            // Held at 2 while full; the step to 1 grants ack.
            cnt   <= cnt - 1'b1;
            ack_q <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (cmd_e'(cmd) == CMD_WRITE)) begin
      mem[idx] <= wdata;
    end
  end

  // Read data is captured at acceptance; later writes cannot alter it.
  always_comb begin
    entry.timer = TIMER_W'(RESP_DELAY);
    entry.data  = '0;
    if (cmd_e'(cmd) == CMD_READ) begin
      entry.data = mem[idx];
    end
  end

  cross_bar_resp_fifo #(
    .DEPTH(RESP_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .din       (entry),
    .pop       (pop),
    .head_data (head_data),
    .head_ready(head_ready),
    .full      (full)
  );

  assign resp  = head_ready;
  assign rdata = head_ready ? head_data : '0;

endmodule

// File: tb/tb_cross_bar_slave_responder.sv
// Bench for cross_bar_slave_responder: three instances with different
// latency/FIFO settings, table vectors, random traffic and a memory model.
module tb_cross_bar_slave_responder;

  localparam int N  = 3;
  localparam int D0 = 1;
  localparam int R0 = 2;
  localparam int D1 = 3;
  localparam int R1 = 5;
  localparam int D2 = 1;
  localparam int R2 = 15;
  localparam int F2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_v   [N];
  logic        req_v   [N];
  logic        cmd_v   [N];
  logic [31:0] addr_v  [N];
  logic [31:0] wdata_v [N];
  logic        ack_v   [N];
  logic        resp_v  [N];
  logic [31:0] rdata_v [N];

  cross_bar_slave_responder #(
    .ACK_DELAY(D0), .RESP_DELAY(R0)
  ) u0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .addr(addr_v[0]),
    .cmd(cmd_v[0]), .wdata(wdata_v[0]), .ack(ack_v[0]),
    .resp(resp_v[0]), .rdata(rdata_v[0])
  );

  cross_bar_slave_responder #(
    .ACK_DELAY(D1), .RESP_DELAY(R1)
  ) u1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .addr(addr_v[1]),
    .cmd(cmd_v[1]), .wdata(wdata_v[1]), .ack(ack_v[1]),
    .resp(resp_v[1]), .rdata(rdata_v[1])
  );

  cross_bar_slave_responder #(
    .ACK_DELAY(D2), .RESP_DELAY(R2), .RESP_FIFO_DEPTH(F2)
  ) u2 (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .addr(addr_v[2]),
    .cmd(cmd_v[2]), .wdata(wdata_v[2]), .ack(ack_v[2]),
    .resp(resp_v[2]), .rdata(rdata_v[2])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int d);
`ifdef CROSS_BAR_SLAVE_RANDOM_STALL_EN
    n_chk++;
    if (lat < d || lat > d + 3) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, lat, d, d + 3);
    end
`else
    check(name, lat, d);
`endif
  endtask

  // Reference model for u0: word memory plus in-order expected responses.
  logic [31:0] model_mem [int];
  logic [31:0] exp_q [$];
  int          ack_c0 [$];
  logic        prev_ack0 = 1'b0;

  function automatic logic [31:0] model_txn(input logic c,
                                            input logic [31:0] a,
                                            input logic [31:0] d);
    int w;
    w = int'((a >> 2) % 256);
    if (c) begin
      model_mem[w] = d;
      return 32'h0;
    end
    return model_mem.exists(w) ? model_mem[w] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rst_v[0]) begin
      prev_ack0 = 1'b0;
    end else begin
      if (ack_v[0]) begin
        ack_c0.push_back(cyc);
        check("ack0_not_consecutive", 32'(prev_ack0), 32'h0);
        check("ack0_with_req", 32'(req_v[0]), 32'h1);
      end
      if (resp_v[0]) begin
        if (exp_q.size() == 0 || ack_c0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp0_unexpected: got resp at cycle %0d expected none", cyc);
        end else begin
          check("resp0_rdata", rdata_v[0], exp_q.pop_front());
          check("resp0_latency", cyc - ack_c0.pop_front(), R0);
        end
      end
      prev_ack0 = ack_v[0];
    end
  end

  int          rc1 [$];
  int          rc2 [$];
  logic [31:0] rd1 [$];
  logic [31:0] rd2 [$];

  always @(negedge clk) begin
    if (resp_v[1]) begin
      rc1.push_back(cyc);
      rd1.push_back(rdata_v[1]);
    end
    if (resp_v[2]) begin
      rc2.push_back(cyc);
      rd2.push_back(rdata_v[2]);
    end
  end

  // Drive one transaction; lat counts cycles from req sampled to ack seen.
  task automatic issue(input int i, input logic c, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e,
                       input bit keep, output int lat, output int acyc);
    @(posedge clk);
    #1;
    req_v[i]   = 1'b1;
    cmd_v[i]   = c;
    addr_v[i]  = a;
    wdata_v[i] = d;
    lat  = -1;
    acyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      lat++;
      if (ack_v[i]) begin
        acyc = cyc;
        break;
      end
    end
    if (acyc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack within 200 cycles", i);
    end else if (i == 0) begin
      exp_q.push_back(e);
    end
    if (!keep) begin
      @(posedge clk);
      #1;
      req_v[i] = 1'b0;
    end
  endtask

  task automatic wait_resps(input int i, input int n);
    int sz;
    sz = 0;
    for (int k = 0; k < 400; k++) begin
      sz = (i == 1) ? rc1.size() : rc2.size();
      if (sz >= n) break;
      @(negedge clk);
    end
    n_chk++;
    if (sz < n) begin
      n_fail++;
      $display("FAIL resp_count dut%0d: got %0d expected %0d", i, sz, n);
    end
  endtask

  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tbl [8];
  int   words [4] = '{0, 1, 2, 4};

  initial begin
    int lat, ac, c1, c2, c3, base, n0, w;
    logic        rc;
    logic [31:0] ra, rdv, re;
    bit          kp;

    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h0,  32'h1,        32'h0};
    tbl[3] = '{1'b1, 32'h4,  32'h2,        32'h0};
    tbl[4] = '{1'b1, 32'h8,  32'h3,        32'h0};
    tbl[5] = '{1'b0, 32'h0,  32'h0,        32'h1};
    tbl[6] = '{1'b0, 32'h4,  32'h0,        32'h2};
    tbl[7] = '{1'b0, 32'h8,  32'h0,        32'h3};

    for (int i = 0; i < N; i++) begin
      rst_v[i]   = 1'b1;
      req_v[i]   = 1'b0;
      cmd_v[i]   = 1'b0;
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_ack", 32'(ack_v[i]), 32'h0);
      check("reset_resp", 32'(resp_v[i]), 32'h0);
      check("reset_rdata", rdata_v[i], 32'h0);
    end
    for (int i = 0; i < N; i++) rst_v[i] = 1'b0;

    // Table vectors on u0: write/read-back and ordered reads.
    for (int t = 0; t < 8; t++) begin
      re = model_txn(tbl[t].c, tbl[t].a, tbl[t].d);
      issue(0, tbl[t].c, tbl[t].a, tbl[t].d, tbl[t].e, 1'b0, lat, ac);
      check_lat("tbl_ack_latency", lat, D0);
    end

    // Back-to-back: write then immediate read of the same word.
    re = model_txn(1'b1, 32'h4, 32'hCAFEF00D);
    issue(0, 1'b1, 32'h4, 32'hCAFEF00D, re, 1'b1, lat, c1);
    re = model_txn(1'b0, 32'h4, 32'h0);
    issue(0, 1'b0, 32'h4, 32'h0, re, 1'b0, lat, c2);
`ifndef CROSS_BAR_SLAVE_RANDOM_STALL_EN
    check("b2b_ack_spacing", c2 - c1, 2);
`endif

    // Random traffic over four known words; upper/lower addr bits are noise.
    for (int k = 0; k < 40; k++) begin
      w   = words[$urandom_range(0, 3)];
      ra  = ($urandom & 32'hFFFF_FC00) | (32'(w) << 2) | ($urandom & 32'h3);
      rc  = 1'($urandom & 1);
      rdv = $urandom;
      kp  = (k != 39) && ($urandom_range(0, 1) == 1);
      re  = model_txn(rc, ra, rdv);
      issue(0, rc, ra, rdv, re, kp, lat, ac);
    end
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("u0_drain", exp_q.size(), 0);

    // Latency instance: ack D1 after req, resp R1 after ack.
    issue(1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, lat, ac);
    check_lat("u1_write_ack_latency", lat, D1);
    wait_resps(1, 1);
    check("u1_write_resp_latency", rc1[0] - ac, R1);
    check("u1_write_rdata", rd1[0], 32'h0);
    issue(1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, lat, ac);
    check_lat("u1_read_ack_latency", lat, D1);
    wait_resps(1, 2);
    check("u1_read_resp_latency", rc1[1] - ac, R1);
    check("u1_read_rdata", rd1[1], 32'h12345678);

    // Backpressure instance: preload, then three reads into a 2-deep FIFO.
    issue(2, 1'b1, 32'h0, 32'hA0, 32'h0, 1'b0, lat, ac);
    issue(2, 1'b1, 32'h4, 32'hB0, 32'h0, 1'b0, lat, ac);
    issue(2, 1'b1, 32'h8, 32'hC0, 32'h0, 1'b0, lat, ac);
    wait_resps(2, 3);
    base = rc2.size();
    issue(2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, lat, c1);
    issue(2, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, lat, c2);
    issue(2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, lat, c3);
    check("bp_second_not_held", 32'(c2 < c1 + R2), 32'h1);
    wait_resps(2, base + 3);
    check("bp_first_resp_cycle", rc2[base] - c1, R2);
    check("bp_third_after_first_resp", 32'(c3 > rc2[base]), 32'h1);
    check("bp_third_granted_promptly", 32'(c3 <= rc2[base] + 1 + 3), 32'h1);
    check("bp_rdata0", rd2[base],     32'hA0);
    check("bp_rdata1", rd2[base + 1], 32'hB0);
    check("bp_rdata2", rd2[base + 2], 32'hC0);
    check("bp_order", 32'(rc2[base] < rc2[base + 1] &&
                          rc2[base + 1] < rc2[base + 2]), 32'h1);

    // Reset with two responses pending: they vanish, memory survives.
    issue(2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, lat, ac);
    issue(2, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, lat, ac);
    @(negedge clk);
    n0 = rc2.size();
    rst_v[2] = 1'b1;
    @(negedge clk);
    check("rst_ack", 32'(ack_v[2]), 32'h0);
    check("rst_resp", 32'(resp_v[2]), 32'h0);
    rst_v[2] = 1'b0;
    repeat (25) @(negedge clk);
    check("rst_no_resp", rc2.size(), n0);
    issue(2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, lat, ac);
    wait_resps(2, n0 + 1);
    if (rd2.size() > n0) check("rst_mem_kept", rd2[n0], 32'hC0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
